// File: rtl/zeroskip_pkg.sv
// Shared constants and types for the zero-skip activation path.
package zeroskip_pkg;

  localparam int unsigned DIN_W  = 64;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SLICES = DIN_W * DATA_W / DIN_W;
  localparam int unsigned CNT_W  = $clog2(SLICES);

  typedef enum logic {
    HDR = 1'b0,
    ACT = 1'b1
  } znz_unpack_state_e;

  typedef struct packed {
    logic [DIN_W-1:0]             znz;
    logic [DIN_W-1:0][DATA_W-1:0] act;
    logic                         last;
  } znz_act_beat_t;

endpackage

// File: rtl/fifo_slice.sv
// Single-entry valid/ready register slice; a pop and a push in the same cycle refill without a bubble.
module fifo_slice #(
  parameter type t = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_vld,
  input  t     in_data,
  output logic in_rdy_c,
  output logic out_vld,
  input  logic out_rdy,
  output t     out_data
);

  logic push;
  logic pop;

  assign in_rdy_c = !out_vld || out_rdy;
  assign push     = in_vld && in_rdy_c;
  assign pop      = out_vld && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      out_vld  <= 1'b0;
    end else if (push) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (pop) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/zeroskip_znz_unpack.sv
// Splits the interleaved header/activation stream into paired ZNZ-slice and activation outputs.
module zeroskip_znz_unpack
  import zeroskip_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic [DIN_W-1:0][DATA_W-1:0] din,
  input  logic                         din_vld_i,
  input  logic                         din_last_i,
  output logic                         din_rdy_o,
  output logic [DIN_W-1:0]             znz_dout,
  output logic                         znz_dout_vld_o,
  input  logic                         znz_dout_rdy_i,
  output logic [DIN_W-1:0][DATA_W-1:0] act_dout,
  output logic                         act_dout_vld_o,
  input  logic                         act_dout_rdy_i,
  output logic                         act_dout_last_o,
  output logic                         err_o
);

  znz_unpack_state_e            state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SLICES-1:0][DIN_W-1:0] znz_reg_q, znz_reg_d;
  logic                         err_q, err_d;

  logic          stage_rdy_c;
  logic          stage_vld;
  logic          push;
  logic          accept;
  znz_act_beat_t beat;
  znz_act_beat_t stage_q;

  assign din_rdy_o = !clear_i && ((state_q == HDR) || stage_rdy_c);
  assign accept    = din_vld_i && din_rdy_o;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HDR;
      cnt_q     <= '0;
      znz_reg_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      znz_reg_q <= znz_reg_d;
      err_q     <= err_d;
    end
  end

  // Next-state, header capture and output-stage write
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    znz_reg_d = znz_reg_q;
    err_d     = err_q;
    push      = 1'b0;
    beat.znz  = znz_reg_q[cnt_q];
    beat.act  = din;
    beat.last = din_last_i || (cnt_q == CNT_W'(SLICES - 1));

    if (clear_i) begin
      state_d = HDR;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        HDR: begin
          // A header flagged as last is malformed: drop it and wait for a real header.
          if (din_last_i) begin
            err_d = 1'b1;
          end else begin
            znz_reg_d = din;
            cnt_d     = '0;
            state_d   = ACT;
          end
        end
        ACT: begin
          push = 1'b1;
          if (beat.last) begin
            state_d = HDR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = HDR;
      endcase
    end
  end

  fifo_slice #(
    .t (znz_act_beat_t)
  ) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_i),
    .in_vld   (push),
    .in_data  (beat),
    .in_rdy_c (stage_rdy_c),
    .out_vld  (stage_vld),
    .out_rdy  (znz_dout_rdy_i && act_dout_rdy_i),
    .out_data (stage_q)
  );

  assign znz_dout        = stage_q.znz;
  assign act_dout        = stage_q.act;
  assign act_dout_last_o = stage_q.last;
  assign znz_dout_vld_o  = stage_vld;
  assign act_dout_vld_o  = stage_vld;
  assign err_o           = err_q;

endmodule

// File: tb/tb_zeroskip_znz_unpack.sv
// Directed bench for zeroskip_znz_unpack: block framing, slice selection, backpressure, error and flush.
module tb_zeroskip_znz_unpack;

  logic              clk;
  logic              rst_n;
  logic              clear_i;
  logic [63:0][7:0]  din;
  logic              din_vld_i;
  logic              din_last_i;
  logic              din_rdy_o;
  logic [63:0]       znz_dout;
  logic              znz_dout_vld_o;
  logic              znz_dout_rdy_i;
  logic [63:0][7:0]  act_dout;
  logic              act_dout_vld_o;
  logic              act_dout_rdy_i;
  logic              act_dout_last_o;
  logic              err_o;

  int n_cmp;
  int n_err;

  zeroskip_znz_unpack dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (clear_i),
    .din             (din),
    .din_vld_i       (din_vld_i),
    .din_last_i      (din_last_i),
    .din_rdy_o       (din_rdy_o),
    .znz_dout        (znz_dout),
    .znz_dout_vld_o  (znz_dout_vld_o),
    .znz_dout_rdy_i  (znz_dout_rdy_i),
    .act_dout        (act_dout),
    .act_dout_vld_o  (act_dout_vld_o),
    .act_dout_rdy_i  (act_dout_rdy_i),
    .act_dout_last_o (act_dout_last_o),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Header whose byte k holds base+k
  function automatic logic [511:0] hdr_pat(input logic [7:0] base);
    logic [511:0] v;
    for (int k = 0; k < 64; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  // Expected slice s of hdr_pat(base): bytes 8s..8s+7 of the header
  function automatic logic [63:0] slice_pat(input logic [7:0] base, input int s);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = base + 8'(8*s + b);
    return v;
  endfunction

  function automatic logic [511:0] act_pat(input logic [7:0] seed);
    logic [511:0] v;
    for (int j = 0; j < 64; j++) v[8*j +: 8] = seed ^ 8'(j * 7);
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one cycle; it must be accepted
  task automatic send(input logic [511:0] d, input logic l);
    din        = d;
    din_last_i = l;
    din_vld_i  = 1'b1;
    #1;
    chk("din_rdy_before_send", 512'(din_rdy_o), 512'(1));
    cycle();
    din_vld_i  = 1'b0;
    din_last_i = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] ez, input logic [511:0] ea, input logic el);
    chk({tag, "_znz_vld"}, 512'(znz_dout_vld_o), 512'(1));
    chk({tag, "_act_vld"}, 512'(act_dout_vld_o), 512'(1));
    chk({tag, "_znz"}, 512'(znz_dout), 512'(ez));
    chk({tag, "_act"}, 512'(act_dout), ea);
    chk({tag, "_last"}, 512'(act_dout_last_o), 512'(el));
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    clear_i        = 1'b0;
    din            = '0;
    din_vld_i      = 1'b0;
    din_last_i     = 1'b0;
    znz_dout_rdy_i = 1'b1;
    act_dout_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 512'(znz_dout_vld_o), 512'(0));
    chk("rst_act_vld", 512'(act_dout_vld_o), 512'(0));
    chk("rst_last", 512'(act_dout_last_o), 512'(0));
    chk("rst_err", 512'(err_o), 512'(0));
    chk("rst_znz", 512'(znz_dout), 512'(0));
    chk("rst_act", 512'(act_dout), 512'(0));
    chk("rst_din_rdy", 512'(din_rdy_o), 512'(1));
    rst_n = 1'b1;
    cycle();

    // Full block, back to back, readies held high: header bubble then 8 outputs
    send(hdr_pat(8'h00), 1'b0);
    chk("full_hdr_bubble", 512'(znz_dout_vld_o), 512'(0));
    for (int k = 0; k < 8; k++) begin
      send(act_pat(8'(k + 1)), 1'b0);
      chk_out($sformatf("full_b%0d", k), slice_pat(8'h00, k), act_pat(8'(k + 1)), k == 7);
    end

    // Short block: next beat is a header, last on the 3rd activation beat
    send(hdr_pat(8'h80), 1'b0);
    chk("short_hdr_bubble", 512'(znz_dout_vld_o), 512'(0));
    for (int k = 0; k < 3; k++) begin
      send(act_pat(8'(8'h20 + k)), k == 2);
      chk_out($sformatf("short_b%0d", k), slice_pat(8'h80, k), act_pat(8'(8'h20 + k)), k == 2);
    end
    send(hdr_pat(8'hC0), 1'b0);
    chk("short_next_hdr_bubble", 512'(znz_dout_vld_o), 512'(0));
    send(act_pat(8'h55), 1'b0);
    chk_out("newhdr_b0", slice_pat(8'hC0, 0), act_pat(8'h55), 1'b0);

    // Split ready: only znz ready for 5 cycles, nothing pops
    act_dout_rdy_i = 1'b0;
    din            = act_pat(8'h66);
    din_vld_i      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("split_din_rdy%0d", i), 512'(din_rdy_o), 512'(0));
      cycle();
      chk_out($sformatf("split_hold%0d", i), slice_pat(8'hC0, 0), act_pat(8'h55), 1'b0);
    end
    act_dout_rdy_i = 1'b1;
    #1;
    chk("split_din_rdy_release", 512'(din_rdy_o), 512'(1));
    cycle();
    din_vld_i = 1'b0;
    chk_out("split_refill", slice_pat(8'hC0, 1), act_pat(8'h66), 1'b0);
    send(act_pat(8'h77), 1'b1);
    chk_out("split_close", slice_pat(8'hC0, 2), act_pat(8'h77), 1'b1);

    // Header flagged last: error, beat dropped, still expecting a header
    send(hdr_pat(8'h10), 1'b1);
    chk("err_set", 512'(err_o), 512'(1));
    chk("err_no_out", 512'(znz_dout_vld_o), 512'(0));
    send(hdr_pat(8'h30), 1'b0);
    chk("err_hdr_bubble", 512'(znz_dout_vld_o), 512'(0));
    chk("err_sticky", 512'(err_o), 512'(1));
    send(act_pat(8'h99), 1'b0);
    chk_out("err_after_b0", slice_pat(8'h30, 0), act_pat(8'h99), 1'b0);
    clear_i = 1'b1;
    #1;
    chk("clear_din_rdy", 512'(din_rdy_o), 512'(0));
    cycle();
    clear_i = 1'b0;
    chk("clear_err", 512'(err_o), 512'(0));
    chk("clear_vld", 512'(znz_dout_vld_o), 512'(0));

    // Flush mid-block with the output stage full
    send(hdr_pat(8'h40), 1'b0);
    for (int k = 0; k < 4; k++) begin
      send(act_pat(8'(8'hA0 + k)), 1'b0);
      chk_out($sformatf("flush_b%0d", k), slice_pat(8'h40, k), act_pat(8'(8'hA0 + k)), 1'b0);
    end
    znz_dout_rdy_i = 1'b0;
    act_dout_rdy_i = 1'b0;
    cycle();
    chk("flush_full", 512'(act_dout_vld_o), 512'(1));
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    chk("flush_vld", 512'(act_dout_vld_o), 512'(0));
    chk("flush_znz_vld", 512'(znz_dout_vld_o), 512'(0));
    znz_dout_rdy_i = 1'b1;
    act_dout_rdy_i = 1'b1;
    send(hdr_pat(8'hE0), 1'b0);
    chk("flush_hdr_bubble", 512'(znz_dout_vld_o), 512'(0));
    send(act_pat(8'h11), 1'b0);
    chk_out("flush_new_b0", slice_pat(8'hE0, 0), act_pat(8'h11), 1'b0);
    send(act_pat(8'h12), 1'b0);
    chk_out("flush_new_b1", slice_pat(8'hE0, 1), act_pat(8'h12), 1'b0);

    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
